// File: rtl/flipper_collision_detector.sv
// flipper_collision_detector
// Accumulates ball/flipper pixel overlap across each video frame and, at the
// frame boundary, emits a one-cycle collision pulse with the first overlap
// point and the flipper speed captured at that point. A per-hit cooldown
// ignores a number of following frames so a ball still in contact does not
// retrigger.
// Optional feature macro: FLIPPER_COLLISION_SIDE_EN adds the hitSide output
// (0 = left flipper, 1 = right flipper, split at SCREEN_MID_X).
module flipper_collision_detector #(
  parameter int COOLDOWN_FRAMES = 4,
  parameter int HIT_DEPTH_MIN   = 1,
  parameter int SCREEN_MID_X    = 320
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               pause,
  input  logic               reset_level,
  input  logic [10:0]        pixelX,
  input  logic [10:0]        pixelY,
  input  logic               drawBall,
  input  logic               drawFlipper,
  input  logic signed [31:0] flipperSpeedX,
  output logic               collision,
  output logic [10:0]        hitX,
  output logic [10:0]        hitY,
  output logic signed [31:0] hitSpeedX,
  output logic [15:0]        overlapCount,
`ifdef FLIPPER_COLLISION_SIDE_EN
  output logic               hitSide,
`endif
  output logic               armed
);

  typedef enum logic {
    ST_ARMED    = 1'b0,
    ST_COOLDOWN = 1'b1
  } state_t;

  localparam logic [15:0] CD_INIT = 16'(COOLDOWN_FRAMES);
  localparam logic [15:0] HIT_MIN = 16'(HIT_DEPTH_MIN);
`ifdef FLIPPER_COLLISION_SIDE_EN
  localparam logic [10:0] MID_X   = 11'(SCREEN_MID_X);
`endif

  // Overlap counter saturates rather than wrapping on huge overlaps.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t             state_q, state_d;
  logic [15:0]        cd_cnt_q, cd_cnt_d;
  logic [15:0]        acc_cnt_q, acc_cnt_d;
  logic               first_seen_q, first_seen_d;
  logic [10:0]        cap_x_q, cap_x_d;
  logic [10:0]        cap_y_q, cap_y_d;
  logic signed [31:0] cap_spd_q, cap_spd_d;
  logic               collision_q, collision_d;
  logic [10:0]        hit_x_q, hit_x_d;
  logic [10:0]        hit_y_q, hit_y_d;
  logic signed [31:0] hit_spd_q, hit_spd_d;
  logic [15:0]        overlap_count_q, overlap_count_d;
`ifdef FLIPPER_COLLISION_SIDE_EN
  logic               hit_side_q, hit_side_d;
`endif

  logic               overlap;
  logic [15:0]        acc_base;
  logic               fs_base;

  assign overlap = drawBall & drawFlipper;

  // Next-state: soft clear, paused frame handling, frame evaluation, accumulation.
  always_comb begin
    state_d         = state_q;
    cd_cnt_d        = cd_cnt_q;
    acc_cnt_d       = acc_cnt_q;
    first_seen_d    = first_seen_q;
    cap_x_d         = cap_x_q;
    cap_y_d         = cap_y_q;
    cap_spd_d       = cap_spd_q;
    collision_d     = 1'b0;
    hit_x_d         = hit_x_q;
    hit_y_d         = hit_y_q;
    hit_spd_d       = hit_spd_q;
    overlap_count_d = overlap_count_q;
`ifdef FLIPPER_COLLISION_SIDE_EN
    hit_side_d      = hit_side_q;
`endif
    acc_base        = acc_cnt_q;
    fs_base         = first_seen_q;

    if (reset_level) begin
      state_d         = ST_ARMED;
      cd_cnt_d        = '0;
      acc_cnt_d       = '0;
      first_seen_d    = 1'b0;
      cap_x_d         = '0;
      cap_y_d         = '0;
      cap_spd_d       = '0;
      hit_x_d         = '0;
      hit_y_d         = '0;
      hit_spd_d       = '0;
      overlap_count_d = '0;
`ifdef FLIPPER_COLLISION_SIDE_EN
      hit_side_d      = 1'b0;
`endif
    end else if (pause) begin
      // A paused frame boundary only discards the partial frame.
      if (startOfFrame) begin
        acc_cnt_d    = '0;
        first_seen_d = 1'b0;
      end
    end else begin
      if (startOfFrame) begin
        overlap_count_d = acc_cnt_q;
        if (state_q == ST_ARMED) begin
          if (acc_cnt_q >= HIT_MIN) begin
            collision_d = 1'b1;
            hit_x_d     = cap_x_q;
            hit_y_d     = cap_y_q;
            hit_spd_d   = cap_spd_q;
`ifdef FLIPPER_COLLISION_SIDE_EN
            hit_side_d  = (cap_x_q >= MID_X);
`endif
            if (COOLDOWN_FRAMES > 0) begin
              state_d  = ST_COOLDOWN;
              cd_cnt_d = CD_INIT;
            end
          end
        end else begin
          cd_cnt_d = cd_cnt_q - 16'd1;
          if (cd_cnt_q <= 16'd1) begin
            cd_cnt_d = '0;
            state_d  = ST_ARMED;
          end
        end
        // The boundary pixel itself opens the new frame.
        acc_base = '0;
        fs_base  = 1'b0;
      end
      acc_cnt_d    = overlap ? sat_inc(acc_base) : acc_base;
      first_seen_d = fs_base | overlap;
      if (overlap && !fs_base) begin
        cap_x_d   = pixelX;
        cap_y_d   = pixelY;
        cap_spd_d = flipperSpeedX;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_ARMED;
      cd_cnt_q        <= '0;
      acc_cnt_q       <= '0;
      first_seen_q    <= 1'b0;
      cap_x_q         <= '0;
      cap_y_q         <= '0;
      cap_spd_q       <= '0;
      collision_q     <= 1'b0;
      hit_x_q         <= '0;
      hit_y_q         <= '0;
      hit_spd_q       <= '0;
      overlap_count_q <= '0;
`ifdef FLIPPER_COLLISION_SIDE_EN
      hit_side_q      <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      cd_cnt_q        <= cd_cnt_d;
      acc_cnt_q       <= acc_cnt_d;
      first_seen_q    <= first_seen_d;
      cap_x_q         <= cap_x_d;
      cap_y_q         <= cap_y_d;
      cap_spd_q       <= cap_spd_d;
      collision_q     <= collision_d;
      hit_x_q         <= hit_x_d;
      hit_y_q         <= hit_y_d;
      hit_spd_q       <= hit_spd_d;
      overlap_count_q <= overlap_count_d;
`ifdef FLIPPER_COLLISION_SIDE_EN
      hit_side_q      <= hit_side_d;
`endif
    end
  end

  assign collision    = collision_q;
  assign hitX         = hit_x_q;
  assign hitY         = hit_y_q;
  assign hitSpeedX    = hit_spd_q;
  assign overlapCount = overlap_count_q;
  assign armed        = (state_q == ST_ARMED);
`ifdef FLIPPER_COLLISION_SIDE_EN
  assign hitSide      = hit_side_q;
`endif

endmodule

// File: tb/tb_flipper_collision_detector.sv
// Scoreboard bench for flipper_collision_detector (COOLDOWN_FRAMES=4,
// HIT_DEPTH_MIN=3). Stimulus pushes expected hits; a monitor pops them
// whenever collision is seen.
module tb_flipper_collision_detector;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               startOfFrame = 1'b0;
  logic               pause = 1'b0;
  logic               reset_level = 1'b0;
  logic [10:0]        pixelX = '0;
  logic [10:0]        pixelY = '0;
  logic               drawBall = 1'b0;
  logic               drawFlipper = 1'b0;
  logic signed [31:0] flipperSpeedX = '0;
  logic               collision;
  logic [10:0]        hitX;
  logic [10:0]        hitY;
  logic signed [31:0] hitSpeedX;
  logic [15:0]        overlapCount;
  logic               armed;
`ifdef FLIPPER_COLLISION_SIDE_EN
  logic               hitSide;
`endif

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;

  typedef struct {
    int          edge_n;
    logic [10:0] x;
    logic [10:0] y;
    logic [31:0] spd;
    logic [15:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  flipper_collision_detector #(
    .COOLDOWN_FRAMES(4),
    .HIT_DEPTH_MIN  (3),
    .SCREEN_MID_X   (320)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .pause        (pause),
    .reset_level  (reset_level),
    .pixelX       (pixelX),
    .pixelY       (pixelY),
    .drawBall     (drawBall),
    .drawFlipper  (drawFlipper),
    .flipperSpeedX(flipperSpeedX),
    .collision    (collision),
    .hitX         (hitX),
    .hitY         (hitY),
    .hitSpeedX    (hitSpeedX),
    .overlapCount (overlapCount),
`ifdef FLIPPER_COLLISION_SIDE_EN
    .hitSide      (hitSide),
`endif
    .armed        (armed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Distractor pixels (never counted), then n overlap pixels on row y0.
  task automatic frame(input int n, input int x0, input int y0, input logic signed [31:0] spd);
    drawBall = 1'b1; drawFlipper = 1'b0; pixelX = 11'd1; pixelY = 11'd2; flipperSpeedX = 32'sd99;
    tick();
    drawBall = 1'b0; drawFlipper = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      drawBall = 1'b1; drawFlipper = 1'b1;
      pixelX = 11'(x0 + i); pixelY = 11'(y0);
      flipperSpeedX = spd + 32'(i);
      tick();
    end
    drawBall = 1'b0; drawFlipper = 1'b0;
    tick();
  endtask

  task automatic sof(input bit hit, input int x, input int y, input logic signed [31:0] spd, input int cnt);
    exp_t e;
    startOfFrame = 1'b1;
    if (hit) begin
      e.edge_n = edge_cnt + 1;
      e.x = 11'(x); e.y = 11'(y); e.spd = spd; e.cnt = 16'(cnt);
      exp_q.push_back(e);
    end
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic level_clear();
    reset_level = 1'b1;
    tick();
    reset_level = 1'b0;
  endtask

  // Monitor: every collision pulse must match the oldest expected hit.
  always @(negedge clk) begin
    if (!reset && collision) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_collision: got collision=1 expected 0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("collision_latency", 32'(edge_cnt), 32'(e.edge_n));
        chk("hitX", 32'(hitX), 32'(e.x));
        chk("hitY", 32'(hitY), 32'(e.y));
        chk("hitSpeedX", hitSpeedX, e.spd);
        chk("hit_overlapCount", 32'(overlapCount), 32'(e.cnt));
      end
    end
  end

  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("rst_collision", 32'(collision), 32'd0);
    chk("rst_hitX", 32'(hitX), 32'd0);
    chk("rst_hitY", 32'(hitY), 32'd0);
    chk("rst_hitSpeedX", hitSpeedX, 32'd0);
    chk("rst_overlapCount", 32'(overlapCount), 32'd0);
    chk("rst_armed", 32'(armed), 32'd1);

    // First hit: 12 pixels from (300,460), speed 5 at first overlap.
    frame(12, 300, 460, 32'sd5);
    sof(1'b1, 300, 460, 32'sd5, 12);
    chk("hit1_armed", 32'(armed), 32'd0);
    chk("hit1_overlapCount", 32'(overlapCount), 32'd12);
    tick();
    chk("hit1_pulse_width", 32'(collision), 32'd0);

    // Four cooldown frames with overlap: no hit, re-arm after the 4th.
    for (int f = 1; f <= 4; f++) begin
      frame(5, 50, 60, 32'sd7);
      sof(1'b0, 0, 0, 32'sd0, 0);
      chk("cd_overlapCount", 32'(overlapCount), 32'd5);
      chk("cd_armed", 32'(armed), (f == 4) ? 32'd1 : 32'd0);
    end
    frame(4, 200, 100, -32'sd3);
    sof(1'b1, 200, 100, -32'sd3, 4);
    chk("hit2_armed", 32'(armed), 32'd0);

    // Two frames bring cd_cnt to 2, then three paused boundaries.
    for (int f = 0; f < 2; f++) begin
      frame(5, 60, 70, 32'sd8);
      sof(1'b0, 0, 0, 32'sd0, 0);
    end
    pause = 1'b1;
    for (int f = 0; f < 3; f++) begin
      frame(6, 70, 80, 32'sd9);
      sof(1'b0, 0, 0, 32'sd0, 0);
      chk("pause_overlapCount", 32'(overlapCount), 32'd5);
      chk("pause_armed", 32'(armed), 32'd0);
    end
    pause = 1'b0;
    sof(1'b0, 0, 0, 32'sd0, 0);
    chk("unpause1_armed", 32'(armed), 32'd0);
    chk("unpause1_overlapCount", 32'(overlapCount), 32'd0);
    sof(1'b0, 0, 0, 32'sd0, 0);
    chk("unpause2_armed", 32'(armed), 32'd1);

    // Depth boundary: 2 overlaps is below HIT_DEPTH_MIN=3.
    frame(2, 10, 20, 32'sd0);
    sof(1'b0, 0, 0, 32'sd0, 0);
    chk("depth2_overlapCount", 32'(overlapCount), 32'd2);
    chk("depth2_armed", 32'(armed), 32'd1);

    // Frame straddling a pause release: only 3 post-release pixels count.
    pause = 1'b1;
    frame(5, 400, 30, 32'sd1);
    pause = 1'b0;
    frame(3, 410, 31, 32'sd2);
    sof(1'b1, 410, 31, 32'sd2, 3);
    chk("straddle_armed", 32'(armed), 32'd0);

    // Soft clear restores the reset state.
    level_clear();
    chk("lvl_armed", 32'(armed), 32'd1);
    chk("lvl_hitX", 32'(hitX), 32'd0);
    chk("lvl_overlapCount", 32'(overlapCount), 32'd0);

    // reset_level on a would-be hit boundary wins.
    frame(5, 123, 45, 32'sd20);
    reset_level = 1'b1;
    sof(1'b0, 0, 0, 32'sd0, 0);
    reset_level = 1'b0;
    chk("lvlsof_collision", 32'(collision), 32'd0);
    chk("lvlsof_armed", 32'(armed), 32'd1);
    chk("lvlsof_overlapCount", 32'(overlapCount), 32'd0);
    chk("lvlsof_hitX", 32'(hitX), 32'd0);
    chk("lvlsof_hitY", 32'(hitY), 32'd0);
    chk("lvlsof_hitSpeedX", hitSpeedX, 32'd0);

    // Overlap on the boundary pixel opens the new frame's count.
    drawBall = 1'b1; drawFlipper = 1'b1;
    pixelX = 11'd77; pixelY = 11'd88; flipperSpeedX = 32'sd11;
    sof(1'b0, 0, 0, 32'sd0, 0);
    drawBall = 1'b0; drawFlipper = 1'b0;
    frame(2, 78, 88, 32'sd12);
    sof(1'b1, 77, 88, 32'sd11, 3);

    // Left / right hits.
    level_clear();
    frame(3, 100, 200, 32'sd4);
    sof(1'b1, 100, 200, 32'sd4, 3);
`ifdef FLIPPER_COLLISION_SIDE_EN
    chk("side_left", 32'(hitSide), 32'd0);
`endif
    level_clear();
    frame(3, 500, 200, 32'sd4);
    sof(1'b1, 500, 200, 32'sd4, 3);
`ifdef FLIPPER_COLLISION_SIDE_EN
    chk("side_right", 32'(hitSide), 32'd1);
`endif

    tick();
    tick();
    tick();
    chk("pending_hits", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flipper_collision_detector.md
Name: flipper_collision_detector

Overview:
- Pairs with flipper_dual_block and consumes its per-pixel drawFlipper and speedX outputs, together with the ball's draw signal.
- Accumulates ball/flipper pixel overlap over each video frame.
- At each frame boundary, decides whether a hit occurred and emits a one-cycle collision event with the hit point and the flipper speed.
- Sits between the flipper block and the ball controller. Per-hit cooldown prevents repeated triggering while the ball is still in contact.

Parameters:
- COOLDOWN_FRAMES, 4: frames ignored after a hit. 0 = no cooldown.
- HIT_DEPTH_MIN, 1: minimum overlapping pixels in one frame to count as a hit.
- SCREEN_MID_X, 320: left/right split column, used only by the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse; marks the first pixel of a new frame
- pause  in  1  freeze detection
- reset_level  in  1  synchronous soft clear
- pixelX  in  11  current pixel column
- pixelY  in  11  current pixel row
- drawBall  in  1  ball covers current pixel
- drawFlipper  in  1  flipper covers current pixel
- flipperSpeedX  in  32  flipper speed, sampled at first overlap
- collision  out  1  one-cycle hit pulse
- hitX  out  11  column of first overlap pixel of the hit frame
- hitY  out  11  row of first overlap pixel of the hit frame
- hitSpeedX  out  32  flipperSpeedX captured at first overlap of the hit frame
- overlapCount  out  16  overlap pixel count of the last evaluated frame
- armed  out  1  high when in ARMED state

Behaviour:
- Reset (reset=1 at a clk edge):
  - All outputs 0, except armed=1.
  - State ARMED; accumulators cleared.
- States: ARMED, COOLDOWN.
  - Encoding is free.
  - armed=1 exactly when the state is ARMED.
- Accumulation (every cycle with pause=0 and startOfFrame=0):
  - overlap = drawBall && drawFlipper.
  - When overlap=1, acc_cnt increments, saturating at 16'hFFFF.
  - The first overlap of the frame (first_seen=0) latches pixelX, pixelY and flipperSpeedX into capture registers and sets first_seen.
- Frame evaluation (startOfFrame=1, pause=0):
  - overlapCount <= acc_cnt.
  - If state=ARMED and acc_cnt >= HIT_DEPTH_MIN:
    - collision=1 on the next cycle only.
    - hitX, hitY and hitSpeedX load from the capture registers.
    - If COOLDOWN_FRAMES>0, go to COOLDOWN with cd_cnt=COOLDOWN_FRAMES; otherwise stay in ARMED.
  - If state=COOLDOWN:
    - cd_cnt decrements.
    - When it reaches 0 on this evaluation, go to ARMED. A hit in the same frame is discarded.
  - acc_cnt and first_seen clear. The startOfFrame pixel itself belongs to the new frame: its overlap is counted as the new frame's first pixel, after the clear.
- Latency: collision is registered and appears exactly 1 cycle after the startOfFrame cycle.
- hitX, hitY and hitSpeedX hold their values until the next hit.
- Pause:
  - While pause=1, there is no accumulation and no collision.
  - startOfFrame during pause clears acc_cnt and first_seen only. cd_cnt is not decremented and overlapCount is not updated.
  - An overlap frame that straddles a pause deassertion evaluates only the pixels seen after the deassertion.
- reset_level=1:
  - Same effect as reset.
  - Wins over a simultaneous startOfFrame, and suppresses a collision pulse scheduled for the next cycle.
- Overlap with drawBall=1 and drawFlipper=0 (or the reverse) is never counted.
- HIT_DEPTH_MIN=0: every ARMED frame evaluates as a hit. This is legal and is used only for test.

Optional Feature:
- Macro: FLIPPER_COLLISION_SIDE_EN.
- When defined:
  - Adds output hitSide (1 bit), loaded together with hitX.
  - hitSide = 0 when the captured X < SCREEN_MID_X (left flipper), 1 otherwise (right flipper). Reset value 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then a frame with 12 overlap pixels starting at (300,460), flipperSpeedX=5, then startOfFrame:
  - collision=1 for exactly 1 cycle, 1 cycle after startOfFrame.
  - hitX=300, hitY=460, hitSpeedX=5, overlapCount=12, armed=0.
- After that hit (COOLDOWN_FRAMES=4), overlap in each of the next 4 frames:
  - No collision.
  - armed returns to 1 after the 4th startOfFrame.
  - Overlap in the 5th frame produces a collision.
- HIT_DEPTH_MIN=3, frame with 2 overlap pixels: no collision and overlapCount=2. Frame with 3 overlap pixels: collision.
- pause=1 across 3 startOfFrame pulses while in COOLDOWN with cd_cnt=2:
  - cd_cnt stays 2 and no collision.
  - After release, 2 frames are needed to re-arm.
- reset_level asserted on the same cycle as a startOfFrame that would hit:
  - No collision pulse; overlapCount=0, armed=1.
  - hitX, hitY and hitSpeedX are 0.
- With FLIPPER_COLLISION_SIDE_EN, hits at X=100 and X=500 (SCREEN_MID_X=320) give hitSide=0 and hitSide=1 respectively.
